// File: rtl/ram_streamer.sv
// Bus-master front end for a small single-port RAM: LOAD writes a valid/ready
// byte stream into consecutive addresses, DUMP reads them back out as a stream.
module ram_streamer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [ADDR_W-1:0]   base_i,
  input  logic [ADDR_W:0]     count_i,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic [DATA_W-1:0]   m_data_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_data_o,
  output logic                ram_we_o,
  input  logic [DATA_W-1:0]   ram_data_i,
  output logic                busy_o,
  output logic                done_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1 << ADDR_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DUMP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic [CNT_W-1:0]  count_clamp;
  logic              slot_free;

  assign count_clamp = (count_i > DEPTH) ? DEPTH : count_i;
  assign slot_free   = !m_valid_q || m_ready_i;

  always_comb begin
    // NOTE: every signal gets a default up front so no path through the case leaves one unassigned (no latches).
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    s_ready_o  = 1'b0;
    ram_we_o   = 1'b0;
    ram_data_o = s_data_i;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ptr_d = base_i;
          rem_d = count_clamp;
          if (count_clamp == '0) state_d = ST_DONE;
          else                   state_d = mode_i ? ST_DUMP : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Write strobe follows valid directly so the byte lands on the handshake edge.
        s_ready_o = 1'b1;
        ram_we_o  = s_valid_i;
        if (s_valid_i) begin
          ptr_d = ptr_q + ADDR_W'(1);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DUMP: begin
        if (slot_free) begin
          if (rem_q != '0) begin
            m_data_d  = ram_data_i;
            m_valid_d = 1'b1;
            ptr_d     = ptr_q + ADDR_W'(1);
            rem_d     = rem_q - CNT_W'(1);
          end else begin
            m_valid_d = 1'b0;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_data_o   = m_data_q;
  assign m_valid_o  = m_valid_q;
  assign ram_addr_o = ptr_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_ram_streamer.sv
// Self-checking bench for ram_streamer: a behavioural 16x8 RAM, a write/read
// scoreboard checked at the negative edge, a transfer table and reset corners.
module tb_ram_streamer;

  typedef struct {
    logic       mode;
    logic [3:0] base;
    logic [4:0] count;
    logic [7:0] seed;
    int         pat;
    logic       poke;
    int         exp_moved;
  } vec_t;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       mode_i = 1'b0;
  logic [3:0] base_i = '0;
  logic [4:0] count_i = '0;
  logic [7:0] s_data_i = '0;
  logic       s_valid_i = 1'b0;
  logic       s_ready_o;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i = 1'b0;
  logic [3:0] ram_addr_o;
  logic [7:0] ram_data_o;
  logic       ram_we_o;
  logic [7:0] ram_data_i;
  logic       busy_o;
  logic       done_o;

  logic [7:0] mem  [16];
  logic [7:0] gold [16];
  logic       pre_we = 1'b0;
  logic [3:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int moved = 0;
  int done_cnt = 0;
  int done_at = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  wr_t        wq[$];
  logic [7:0] dq[$];
  vec_t       vecs[11];

  ram_streamer #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .base_i(base_i), .count_i(count_i), .s_data_i(s_data_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .m_data_o(m_data_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_we_o(ram_we_o), .ram_data_i(ram_data_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (pre_we)        mem[pre_addr]   <= pre_data;
    else if (ram_we_o) mem[ram_addr_o] <= ram_data_o;
  end
  assign ram_data_i = mem[ram_addr_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    busy_o,     0);
    check({tag, "_done"},    done_o,     0);
    check({tag, "_mvalid"},  m_valid_o,  0);
    check({tag, "_mdata"},   m_data_o,   0);
    check({tag, "_sready"},  s_ready_o,  0);
    check({tag, "_we"},      ram_we_o,   0);
    check({tag, "_addr"},    ram_addr_o, 0);
  endtask

  // Scoreboard monitor: inputs change just after posedge, so a negedge sample
  // shows exactly what the next posedge will act on.
  always @(negedge clk_i) begin
    wr_t        w;
    logic [7:0] d;
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_valid_o, 1);
        check("stall_data", m_data_o, prev_data);
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
      if (ram_we_o) begin
        moved++;
        if (wq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, expected none", ram_addr_o, ram_data_o);
        end else begin
          w = wq.pop_front();
          check("wr_addr", ram_addr_o, w.addr);
          check("wr_data", ram_data_o, w.data);
        end
      end
      if (m_valid_o && m_ready_i) begin
        moved++;
        if (dq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_byte: data %0h, expected none", m_data_o);
        end else begin
          d = dq.pop_front();
          check("dump_data", m_data_o, d);
        end
      end
      if (done_o) begin
        done_cnt++;
        done_at = cyc;
      end
    end
  end

  task automatic send_byte(input logic [7:0] data);
    int c;
    s_data_i  = data;
    s_valid_i = 1'b1;
    c = 0;
    @(negedge clk_i);
    while (!s_ready_o && c < 20) begin
      @(negedge clk_i);
      c++;
    end
    check("sready_timeout", (c < 20), 1);
    @(posedge clk_i); #1;
  endtask

  task automatic run_xfer(input vec_t v);
    int n, t0, c, lat;
    logic [3:0] a;
    n = (v.count > 5'd16) ? 16 : int'(v.count);
    for (int k = 0; k < n; k++) begin
      a = v.base + 4'(k);
      if (!v.mode) begin
        wq.push_back('{a, v.seed + 8'(k)});
        gold[a] = v.seed + 8'(k);
      end else begin
        dq.push_back(gold[a]);
      end
    end
    moved = 0;
    done_cnt = 0;
    @(posedge clk_i); #1;
    start_i = 1'b1; mode_i = v.mode; base_i = v.base; count_i = v.count;
    @(posedge clk_i); #1;
    t0 = cyc;
    start_i = 1'b0;
    if (!v.mode) begin
      for (int k = 0; k < n; k++) begin
        if (v.pat == 2) begin
          s_valid_i = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
        end
        if (v.poke && k == 1) begin
          start_i = 1'b1; mode_i = 1'b1; base_i = 4'd9; count_i = 5'd3;
        end
        send_byte(v.seed + 8'(k));
        start_i = 1'b0;
      end
      s_valid_i = 1'b0;
    end else begin
      for (c = 0; c < 200 && done_cnt == 0; c++) begin
        if (v.pat == 0)      m_ready_i = 1'b1;
        else if (v.pat == 1) m_ready_i = ~c[0];
        else                 m_ready_i = 1'($urandom_range(0, 1));
        @(negedge clk_i);
        if (done_cnt == 0) begin @(posedge clk_i); #1; end
      end
      m_ready_i = 1'b0;
    end
    c = 0;
    while (done_cnt == 0 && c < 40) begin
      @(negedge clk_i);
      c++;
    end
    lat = done_at - t0;
    repeat (2) @(negedge clk_i);
    check("done_once", done_cnt, 1);
    check("idle_after", busy_o, 0);
    check("moved", moved, v.exp_moved);
    check("wq_empty", wq.size(), 0);
    check("dq_empty", dq.size(), 0);
    if (v.pat == 0 && done_cnt == 1)
      check("latency", lat, (n == 0) ? 0 : (v.mode ? n + 1 : n));
    wq.delete();
    dq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 4'd0,  5'd16, 8'h00, 0, 1'b0, 16};
    vecs[1]  = '{1'b1, 4'd0,  5'd16, 8'h00, 0, 1'b0, 16};
    vecs[2]  = '{1'b0, 4'd14, 5'd4,  8'hA1, 0, 1'b0, 4};
    vecs[3]  = '{1'b1, 4'd14, 5'd4,  8'h00, 0, 1'b0, 4};
    vecs[4]  = '{1'b1, 4'd0,  5'd16, 8'h00, 1, 1'b0, 16};
    vecs[5]  = '{1'b1, 4'd3,  5'd10, 8'h00, 2, 1'b0, 10};
    vecs[6]  = '{1'b0, 4'd0,  5'd0,  8'h55, 0, 1'b0, 0};
    vecs[7]  = '{1'b1, 4'd5,  5'd0,  8'h00, 0, 1'b0, 0};
    vecs[8]  = '{1'b0, 4'd6,  5'd20, 8'h40, 2, 1'b0, 16};
    vecs[9]  = '{1'b1, 4'd9,  5'd31, 8'h00, 2, 1'b0, 16};
    vecs[10] = '{1'b0, 4'd2,  5'd5,  8'h70, 0, 1'b1, 5};

    // Reset state, then preload the RAM with a known pattern while held in reset.
    #1;
    check_idle("reset");
    for (int i = 0; i < 16; i++) begin
      @(posedge clk_i); #1;
      pre_we = 1'b1; pre_addr = 4'(i); pre_data = 8'hE0 ^ 8'(i);
      gold[i] = 8'hE0 ^ 8'(i);
    end
    @(posedge clk_i); #1;
    pre_we = 1'b0;
    rst_i  = 1'b0;
    @(posedge clk_i); #1;

    // Reset mid-LOAD after 3 of 8 bytes: nothing further may be written.
    for (int k = 0; k < 3; k++) begin
      wq.push_back('{4'(4 + k), 8'h30 + 8'(k)});
      gold[4 + k] = 8'h30 + 8'(k);
    end
    start_i = 1'b1; mode_i = 1'b0; base_i = 4'd4; count_i = 5'd8;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 0; k < 3; k++) send_byte(8'h30 + 8'(k));
    rst_i = 1'b1;
    #1;
    check_idle("midload_rst");
    @(posedge clk_i); #1;
    check_idle("midload_hold");
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("midload_no_resume", busy_o, 0);
    s_valid_i = 1'b0;
    check("midload_wq", wq.size(), 0);
    for (int i = 4; i < 8; i++) check("midload_ram", mem[i], gold[i]);

    // Transfer table.
    for (int i = 0; i < 11; i++) run_xfer(vecs[i]);

    // Final RAM image against the bench's own record of every write.
    for (int i = 0; i < 16; i++) check("ram_final", mem[i], gold[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
